// File: rtl/ic_dest_part_if.sv
// Destination-partition bus: stage-1 request/accept, stage-2 flit, per-node delivery.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif
`ifndef FLIT_WIDTH
`define FLIT_WIDTH 8
`endif

interface ic_dest_part_if #(
  parameter int unsigned N     = 2,
  parameter int unsigned WIDTH = `FLIT_WIDTH
);
  logic                   s1_valid_in;
  logic                   s1_valid_urgent_in;
  logic [`ADDR_WIDTH-1:0] s1_nexthop_in;
  logic                   s1_accept;
  logic [WIDTH-1:0]       s2_data_in;
  logic [`ADDR_WIDTH-1:0] s2_nexthop_in;
  logic [N-1:0]           dst_valid;
  logic [N*WIDTH-1:0]     dst_data_out;
  logic [N-1:0]           dst_dequeue;

  // Source/consumer side
  modport master (
    output s1_valid_in, s1_valid_urgent_in, s1_nexthop_in,
    output s2_data_in, s2_nexthop_in, dst_dequeue,
    input  s1_accept, dst_valid, dst_data_out
  );

  // Partition side
  modport slave (
    input  s1_valid_in, s1_valid_urgent_in, s1_nexthop_in,
    input  s2_data_in, s2_nexthop_in, dst_dequeue,
    output s1_accept, dst_valid, dst_data_out
  );
endinterface

// File: rtl/ic_dest_part.sv
// Destination partition: one-entry slot per local node, two-stage request/flit delivery.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif
`ifndef FLIT_WIDTH
`define FLIT_WIDTH 8
`endif

module ic_dest_part #(
  parameter int unsigned            N     = 2,
  parameter int unsigned            WIDTH = `FLIT_WIDTH,
  parameter logic [`ADDR_WIDTH-1:0] BASE  = '0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  ic_dest_part_if.slave      bus,
  output logic               can_increment,
  output logic               addr_error,
  output logic [15:0]        flit_count
);
  localparam int unsigned AW   = `ADDR_WIDTH;
  localparam int unsigned IDXW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    SLOT_FREE     = 2'd0,
    SLOT_RESERVED = 2'd1,
    SLOT_FULL     = 2'd2
  } slot_e;

  slot_e            r_slot [N];
  logic [WIDTH-1:0] r_data [N];
  logic             r_pend;
  logic [IDXW-1:0]  r_pidx;
  logic             r_err;
  logic [15:0]      r_cnt;

  logic [AW-1:0]    w_idx_full;
  logic [AW-1:0]    w_s2_idx_full;
  logic [IDXW-1:0]  w_idx;
  logic             w_in_range;
  logic             w_slot_ok;
  logic             w_accept;

  // Decode the stage-1 address relative to this partition's base
  always_comb begin
    w_idx_full    = bus.s1_nexthop_in - BASE;
    w_s2_idx_full = bus.s2_nexthop_in - BASE;
    w_idx         = w_idx_full[IDXW-1:0];
    w_in_range    = (32'(w_idx_full) < N);
  end

  // Target slot can take a request: free, or full and being drained this cycle
  always_comb begin
    w_slot_ok = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (w_idx_full == AW'(i)) begin
        w_slot_ok = (r_slot[i] == SLOT_FREE) ||
                    ((r_slot[i] == SLOT_FULL) && bus.dst_dequeue[i]);
      end
    end
  end

  // Combinational accept and urgency back-pressure
  always_comb begin
    w_accept      = bus.s1_valid_in & enable & w_in_range & w_slot_ok;
    bus.s1_accept = w_accept;
    can_increment = ~(bus.s1_valid_in & bus.s1_valid_urgent_in & ~w_accept);
  end

  // Flatten slot state onto the delivery bus
  always_comb begin
    bus.dst_valid    = '0;
    bus.dst_data_out = '0;
    for (int i = 0; i < N; i++) begin
      bus.dst_valid[i]                  = (r_slot[i] == SLOT_FULL);
      bus.dst_data_out[i*WIDTH +: WIDTH] = r_data[i];
    end
  end

  always_comb begin
    addr_error = r_err;
    flit_count = r_cnt;
  end

  // Slot, pending and status state; later assignments take priority
  // (accept on a draining slot lands in RESERVED rather than FREE)
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        r_slot[i] <= SLOT_FREE;
        r_data[i] <= '0;
      end
      r_pend <= 1'b0;
      r_pidx <= '0;
      r_err  <= 1'b0;
      r_cnt  <= '0;
    end else if (enable) begin
      for (int i = 0; i < N; i++) begin
        if (bus.dst_dequeue[i] && (r_slot[i] == SLOT_FULL)) begin
          r_slot[i] <= SLOT_FREE;
        end
      end
      if (r_pend) begin
        r_slot[r_pidx] <= SLOT_FULL;
        r_data[r_pidx] <= bus.s2_data_in;
        r_cnt          <= r_cnt + 16'd1;
        r_pend         <= 1'b0;
        if (w_s2_idx_full != AW'(r_pidx)) begin
          r_err <= 1'b1;
        end
      end
      if (w_accept) begin
        r_slot[w_idx] <= SLOT_RESERVED;
        r_pidx        <= w_idx;
        r_pend        <= 1'b1;
      end
      if (bus.s1_valid_in && !w_in_range) begin
        r_err <= 1'b1;
      end
    end
  end
endmodule

// File: doc/ic_dest_part.md
IC_DEST_PART -- requirements
Module: ic_dest_part

Interface
REQ-001 Parameter N, default 2, number of destination nodes served by this partition (N >= 1).
REQ-002 Parameter WIDTH, default `FLIT_WIDTH, flit data width.
REQ-003 Parameter BASE, default 0, router address mapped to local node 0; width `ADDR_WIDTH.
REQ-004 clock  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 enable  input  1  simulation-step enable; no state changes while low.
REQ-007 s1_valid_in  input  1  stage-1 request present from the selected source partition.
REQ-008 s1_valid_urgent_in  input  1  the stage-1 request is urgent.
REQ-009 s1_nexthop_in  input  `ADDR_WIDTH  stage-1 destination router address.
REQ-010 s1_accept  output  1  combinational; the stage-1 request is accepted this cycle.
REQ-011 s2_data_in  input  WIDTH  stage-2 flit, valid one enabled cycle after an accepted stage-1 request.
REQ-012 s2_nexthop_in  input  `ADDR_WIDTH  stage-2 address; must equal the accepted stage-1 address.
REQ-013 can_increment  output  1  low while an urgent request is blocked.
REQ-014 dst_valid  output  N  per-node flit-available flag.
REQ-015 dst_data_out  output  N*WIDTH  per-node flit; node i occupies bits [(i+1)*WIDTH-1 : i*WIDTH].
REQ-016 dst_dequeue  input  N  per-node consume strobe; ignored when the matching dst_valid bit is low.
REQ-017 addr_error  output  1  sticky flag for an out-of-range request.
REQ-018 flit_count  output  16  count of flits delivered into slots.

Function
REQ-019 The decode shall compute idx = s1_nexthop_in - BASE, modulo 2^`ADDR_WIDTH; the request is in range iff idx < N.
REQ-020 Each node shall have a one-entry slot with state FREE, RESERVED or FULL; dst_valid[i] is high iff slot i is FULL.
REQ-021 s1_accept shall be s1_valid_in & enable & in-range & (slot[idx] FREE | (slot[idx] FULL & dst_dequeue[idx])).
REQ-022 On accept at edge t, the block shall latch idx into the pending register, set pending-valid and move slot[idx] to RESERVED.
REQ-023 At the next enabled edge with pending-valid set, the block shall write s2_data_in into slot[pending idx], set it FULL and clear pending-valid, giving a one-cycle delivery latency.
REQ-024 If s2_nexthop_in - BASE differs from the pending idx at that edge, the flit shall still be written to the pending idx and addr_error shall be set.
REQ-025 An accept and an s2 write shall both be allowed in the same cycle, giving back-to-back throughput of one flit per cycle across different nodes.
REQ-026 dst_dequeue[i] with slot i FULL shall move the slot to FREE, unless the same edge accepts a new request for i, in which case the slot goes to RESERVED.
REQ-027 A dequeue on a FREE or RESERVED slot shall have no effect.
REQ-028 An out-of-range s1_valid_in with enable high shall not be accepted and shall set addr_error, which stays set until reset.
REQ-029 can_increment shall be ~(s1_valid_in & s1_valid_urgent_in & ~s1_accept).
REQ-030 flit_count shall increment by 1 per s2 write and wrap from 0xFFFF to 0.
REQ-031 While enable is low: s1_accept = 0; slots, the pending register, flit_count and addr_error hold; dst_dequeue is ignored.
REQ-032 For N == 1, idx width shall be 1 bit and only idx 0 is in range.

Reset
REQ-033 On reset, all slots shall go to FREE and pending-valid shall be cleared.
REQ-034 On reset, dst_valid = 0, dst_data_out = 0, flit_count = 0 and addr_error = 0.
REQ-035 Reset shall override enable and any in-flight stage-2 transfer; that flit is dropped.
REQ-036 Reset shall take effect only on a clock edge (synchronous).

Verification
REQ-037 N=2, BASE=4: s1 nexthop=5 valid, next cycle s2_data=0xA5 -> s1_accept=1; one edge later dst_valid=2'b10, node-1 data=0xA5, flit_count=1.
REQ-038 Slot 0 FULL, no dequeue, s1 nexthop=4 urgent -> s1_accept=0, can_increment=0; assert dst_dequeue[0] -> s1_accept=1 in that same cycle, can_increment=1.
REQ-039 Back-to-back requests to 4 then 5 on consecutive cycles -> both accepted; both dst_valid bits set on successive edges with the correct data.
REQ-040 s1 nexthop=7 (out of range) -> s1_accept=0, addr_error=1 from the next edge and held through later traffic.
REQ-041 Accept a request, assert reset on the stage-2 edge -> dst_valid=0, flit_count=0, slot FREE; a new request is accepted immediately after reset.
REQ-042 enable=0 for 3 cycles with a pending request -> no state change; the s2 write completes on the first enabled edge.
